// File: rtl/debounce_ctrl_ers.sv
// debounce_ctrl_ers: push-button debouncer. A two-flop synchronizer feeds a
// four-state accept/reject FSM that is clocked by a local prescaler tick. The
// FSM produces a clean level and one-cycle press/release strobes.
module debounce_ctrl_ers #(
    parameter int PRESCALE = 4,
    parameter int STABLE_N = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic pb_in,
    output logic pb_clean,
    output logic press,
    // 'release' is a reserved word, so the release strobe carries a suffix
    output logic release_pulse,
    output logic busy
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int SW = $clog2(STABLE_N + 1);

    localparam logic [PW-1:0] PRE_LAST  = PW'(PRESCALE - 1);
    localparam logic [SW-1:0] STAB_LAST = SW'(STABLE_N - 1);

    typedef enum logic [1:0] {
        RELEASED    = 2'b00,
        ARM_PRESS   = 2'b01,
        PRESSED     = 2'b10,
        ARM_RELEASE = 2'b11
    } state_t;

    state_t          state;
    logic            sync1;
    logic            sync2;
    logic [PW-1:0]   pre_cnt;
    logic [SW-1:0]   stab_cnt;
    logic            tick;

    // Two-flop synchronizer for the asynchronous pin; frozen while disabled
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else if (enable) begin
            sync1 <= pb_in;
            sync2 <= sync1;
        end
    end

    // Sample tick is asserted during the last count of the prescaler period
    assign tick = (pre_cnt == PRE_LAST);

    // Prescaler counts 0..PRESCALE-1 on enabled cycles and wraps
    always_ff @(posedge clk) begin
        if (reset) begin
            pre_cnt <= '0;
        end else if (enable) begin
            if (tick) begin
                pre_cnt <= '0;
            end else begin
                pre_cnt <= pre_cnt + PW'(1);
            end
        end
    end

    // Accept/reject FSM: a change is taken only after STABLE_N equal tick
    // samples; any opposite sample drops back to the current base state
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= RELEASED;
            stab_cnt      <= '0;
            pb_clean      <= 1'b0;
            press         <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            press         <= 1'b0;
            release_pulse <= 1'b0;
            if (enable && tick) begin
                case (state)
                    RELEASED: begin
                        if (sync2) begin
                            state    <= ARM_PRESS;
                            stab_cnt <= SW'(1);
                        end
                    end
                    ARM_PRESS: begin
                        if (!sync2) begin
                            state    <= RELEASED;
                            stab_cnt <= '0;
                        end else if (stab_cnt == STAB_LAST) begin
                            state    <= PRESSED;
                            stab_cnt <= '0;
                            pb_clean <= 1'b1;
                            press    <= 1'b1;
                        end else begin
                            stab_cnt <= stab_cnt + SW'(1);
                        end
                    end
                    PRESSED: begin
                        if (!sync2) begin
                            state    <= ARM_RELEASE;
                            stab_cnt <= SW'(1);
                        end
                    end
                    ARM_RELEASE: begin
                        if (sync2) begin
                            state    <= PRESSED;
                            stab_cnt <= '0;
                        end else if (stab_cnt == STAB_LAST) begin
                            state         <= RELEASED;
                            stab_cnt      <= '0;
                            pb_clean      <= 1'b0;
                            release_pulse <= 1'b1;
                        end else begin
                            stab_cnt <= stab_cnt + SW'(1);
                        end
                    end
                    default: begin
                        state    <= RELEASED;
                        stab_cnt <= '0;
                    end
                endcase
            end
        end
    end

    // Arm states are the odd encodings, so busy is the state LSB
    assign busy = state[0];

endmodule

// File: tb/tb_debounce_ctrl_ers.sv
// tb_debounce_ctrl_ers: scenario tasks plus a randomized run, all checked
// against a run-length model of the debouncing rules.
module tb_debounce_ctrl_ers;

    localparam int PRESCALE = 4;
    localparam int STABLE_N = 4;

    logic clk = 1'b0;
    logic reset;
    logic enable;
    logic pb_in;
    logic pb_clean;
    logic press;
    logic release_pulse;
    logic busy;

    int vectors    = 0;
    int miscompares = 0;

    // Model: pipeline of the pin, a free-running phase counter, and the
    // number of consecutive tick samples that disagree with the clean level.
    int m_s1, m_s2, m_phase, m_run;
    bit m_clean, m_press, m_rel;

    debounce_ctrl_ers #(
        .PRESCALE(PRESCALE),
        .STABLE_N(STABLE_N)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .pb_in        (pb_in),
        .pb_clean     (pb_clean),
        .press        (press),
        .release_pulse(release_pulse),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] expv();
        return {m_clean, m_press, m_rel, (m_run != 0)};
    endfunction

    function automatic logic [3:0] gotv();
        return {pb_clean, press, release_pulse, busy};
    endfunction

    task automatic model_step(input bit pb, input bit en, input bit rst);
        if (rst) begin
            m_s1 = 0; m_s2 = 0; m_phase = 0; m_run = 0;
            m_clean = 0; m_press = 0; m_rel = 0;
        end else begin
            m_press = 0;
            m_rel = 0;
            if (en) begin
                if (m_phase == PRESCALE - 1) begin
                    if (m_s2 != int'(m_clean)) begin
                        m_run = m_run + 1;
                        if (m_run == STABLE_N) begin
                            m_clean = !m_clean;
                            m_press = m_clean;
                            m_rel   = !m_clean;
                            m_run   = 0;
                        end
                    end else begin
                        m_run = 0;
                    end
                end
                m_phase = (m_phase + 1) % PRESCALE;
                m_s2 = m_s1;
                m_s1 = int'(pb);
            end
        end
    endtask

    // One clock: inputs applied after the falling edge, outputs seen at the next
    task automatic drive(input bit pb, input bit en, input bit rst);
        pb_in  = pb;
        enable = en;
        reset  = rst;
        model_step(pb, en, rst);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        int first;
        int npress;
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b1, 1'b1);
            vectors++;
            if (gotv() !== 4'b0000) begin
                miscompares++;
                $display("FAIL reset_outputs cyc=%0d got=%b exp=0000", i, gotv());
            end
        end
        first = -1;
        npress = 0;
        for (int k = 1; k <= 30; k++) begin
            drive(1'b1, 1'b1, 1'b0);
            vectors++;
            if (gotv() !== expv()) begin
                miscompares++;
                $display("FAIL reset_release_model edge=%0d got=%b exp=%b", k, gotv(), expv());
            end
            if (press === 1'b1) begin
                npress++;
                if (first < 0) first = k;
            end
        end
        vectors++;
        if (first < 15 || first > 18 || npress != 1) begin
            miscompares++;
            $display("FAIL reset_first_press edge=%0d count=%0d required edge 15..18 count 1", first, npress);
        end
    endtask

    task automatic test_bouncy_release();
        int first;
        int nrel;
        nrel = 0;
        for (int t = 0; t < 4; t++) begin
            for (int c = 0; c < 5; c++) begin
                drive((t % 2) == 1, 1'b1, 1'b0);
                vectors++;
                if (gotv() !== expv()) begin
                    miscompares++;
                    $display("FAIL bouncy_release_model seg=%0d got=%b exp=%b", t, gotv(), expv());
                end
                if (release_pulse === 1'b1) nrel++;
            end
        end
        vectors++;
        if (nrel != 0 || pb_clean !== 1'b1) begin
            miscompares++;
            $display("FAIL bouncy_release_early rel=%0d clean=%b required rel 0 clean 1", nrel, pb_clean);
        end
        first = -1;
        for (int k = 1; k <= 40; k++) begin
            drive(1'b0, 1'b1, 1'b0);
            vectors++;
            if (gotv() !== expv()) begin
                miscompares++;
                $display("FAIL bouncy_release_hold edge=%0d got=%b exp=%b", k, gotv(), expv());
            end
            if (release_pulse === 1'b1) begin
                nrel++;
                if (first < 0) first = k;
            end
        end
        vectors++;
        if (first < 15 || first > 18 || nrel != 1 || pb_clean !== 1'b0) begin
            miscompares++;
            $display("FAIL bouncy_release_accept edge=%0d count=%0d clean=%b required edge 15..18 count 1 clean 0",
                     first, nrel, pb_clean);
        end
    endtask

    task automatic test_clean_press();
        int first;
        int npress;
        int nrel;
        int nbusy;
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 1'b0);
        first = -1; npress = 0; nrel = 0; nbusy = 0;
        for (int k = 1; k <= 100; k++) begin
            drive(1'b1, 1'b1, 1'b0);
            vectors++;
            if (gotv() !== expv()) begin
                miscompares++;
                $display("FAIL clean_press_model edge=%0d got=%b exp=%b", k, gotv(), expv());
            end
            if (press === 1'b1) begin
                npress++;
                if (first < 0) first = k;
            end
            if (release_pulse === 1'b1) nrel++;
            if (busy === 1'b1) nbusy++;
        end
        vectors++;
        if (first < 15 || first > 18 || npress != 1 || nrel != 0) begin
            miscompares++;
            $display("FAIL clean_press_strobe edge=%0d press=%0d rel=%0d required edge 15..18 press 1 rel 0",
                     first, npress, nrel);
        end
        vectors++;
        if (nbusy != (STABLE_N - 1) * PRESCALE || pb_clean !== 1'b1) begin
            miscompares++;
            $display("FAIL clean_press_busy busy_cycles=%0d clean=%b required %0d clean 1",
                     nbusy, pb_clean, (STABLE_N - 1) * PRESCALE);
        end
    endtask

    task automatic test_bouncy_press();
        int npress;
        int nbusy;
        for (int i = 0; i < 30; i++) drive(1'b0, 1'b1, 1'b0);
        npress = 0; nbusy = 0;
        for (int t = 0; t < 6; t++) begin
            for (int c = 0; c < 5; c++) begin
                drive((t % 2) == 0, 1'b1, 1'b0);
                vectors++;
                if (gotv() !== expv()) begin
                    miscompares++;
                    $display("FAIL bouncy_press_model seg=%0d got=%b exp=%b", t, gotv(), expv());
                end
                if (press === 1'b1) npress++;
                if (busy === 1'b1) nbusy++;
            end
        end
        for (int k = 0; k < 30; k++) begin
            drive(1'b0, 1'b1, 1'b0);
            if (press === 1'b1) npress++;
        end
        vectors++;
        if (npress != 0 || pb_clean !== 1'b0 || busy !== 1'b0 || nbusy == 0) begin
            miscompares++;
            $display("FAIL bouncy_press_reject press=%0d clean=%b busy=%b busy_cycles=%0d required 0 0 0 >0",
                     npress, pb_clean, busy, nbusy);
        end
    endtask

    task automatic test_enable_freeze();
        int n;
        int first;
        n = 0;
        while (m_run != 2 && n < 30) begin
            drive(1'b1, 1'b1, 1'b0);
            n++;
        end
        vectors++;
        if (m_run != 2 || gotv() !== 4'b0001) begin
            miscompares++;
            $display("FAIL freeze_arm got=%b exp=0001 steps=%0d", gotv(), n);
        end
        for (int i = 0; i < 20; i++) begin
            drive(1'($urandom_range(0, 1)), 1'b0, 1'b0);
            vectors++;
            if (gotv() !== 4'b0001 || gotv() !== expv()) begin
                miscompares++;
                $display("FAIL freeze_hold cyc=%0d got=%b exp=0001", i, gotv());
            end
        end
        first = -1;
        for (int k = 1; k <= 12; k++) begin
            drive(1'b1, 1'b1, 1'b0);
            vectors++;
            if (gotv() !== expv()) begin
                miscompares++;
                $display("FAIL freeze_resume_model edge=%0d got=%b exp=%b", k, gotv(), expv());
            end
            if (press === 1'b1 && first < 0) first = k;
        end
        vectors++;
        if (first != 2 * PRESCALE) begin
            miscompares++;
            $display("FAIL freeze_resume_press edge=%0d required %0d", first, 2 * PRESCALE);
        end
    endtask

    task automatic test_reset_mid_pressed();
        int first;
        int nrel;
        for (int i = 0; i < 5; i++) drive(1'b1, 1'b1, 1'b0);
        vectors++;
        if (pb_clean !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_reset_precond clean=%b required 1", pb_clean);
        end
        drive(1'b1, 1'b1, 1'b1);
        vectors++;
        if (gotv() !== 4'b0000) begin
            miscompares++;
            $display("FAIL mid_reset_clear got=%b exp=0000", gotv());
        end
        first = -1; nrel = 0;
        for (int k = 1; k <= 30; k++) begin
            drive(1'b1, 1'b1, 1'b0);
            vectors++;
            if (gotv() !== expv()) begin
                miscompares++;
                $display("FAIL mid_reset_model edge=%0d got=%b exp=%b", k, gotv(), expv());
            end
            if (press === 1'b1 && first < 0) first = k;
            if (release_pulse === 1'b1) nrel++;
        end
        vectors++;
        if (first < 15 || first > 18 || nrel != 0) begin
            miscompares++;
            $display("FAIL mid_reset_repress edge=%0d rel=%0d required edge 15..18 rel 0", first, nrel);
        end
    endtask

    task automatic test_random();
        bit pb;
        bit en;
        bit rst;
        int hold;
        pb = 0; hold = 0;
        for (int i = 0; i < 3000; i++) begin
            if (hold == 0) begin
                pb = !pb;
                hold = $urandom_range(1, 30);
            end
            hold--;
            en  = ($urandom_range(0, 9) != 0);
            rst = ($urandom_range(0, 199) == 0);
            drive(pb, en, rst);
            vectors++;
            if (gotv() !== expv() || (press === 1'b1 && release_pulse === 1'b1)) begin
                miscompares++;
                $display("FAIL random cyc=%0d got=%b exp=%b", i, gotv(), expv());
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        enable = 1'b1;
        pb_in = 1'b0;
        m_s1 = 0; m_s2 = 0; m_phase = 0; m_run = 0;
        m_clean = 0; m_press = 0; m_rel = 0;
        @(negedge clk);
        test_reset();
        test_bouncy_release();
        test_clean_press();
        test_bouncy_press();
        test_enable_freeze();
        test_reset_mid_pressed();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/debounce_ctrl_ers.md
# debounce_ctrl_ers

Sequencing controller for push-button debouncing: synchronizes a raw button input, generates its own sample tick from a prescaler, and runs a four-state FSM that accepts a level change only after `STABLE_N` consecutive identical samples. Outputs a clean level plus single-cycle press and release strobes. Sits between the board pin and the user logic, in place of the free-running counter plus shift-register pairing, and follows the same `clk`/`enable`/`reset` conventions as the `_ers` blocks.

## Interface
- `PRESCALE`, default 4: enabled `clk` cycles per sample tick; legal range ≥1.
- `STABLE_N`, default 4: consecutive equal tick samples required to accept a change; legal range ≥2.
- `clk` in 1: single clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-high; dominates `enable`.
- `enable` in 1: when 0, all state freezes.
- `pb_in` in 1: raw, asynchronous, bouncing button input.
- `pb_clean` out 1: debounced level, registered.
- `press` out 1: one-cycle strobe on accepted 0→1.
- `release` out 1: one-cycle strobe on accepted 1→0.
- `busy` out 1: 1 while in an ARM state, registered.

## Operation
- Synchronizer: `sync1 <= pb_in`, `sync2 <= sync1`. Updates only when `enable`=1. Only `sync2` feeds the FSM.
- Prescaler:
  - `pre_cnt` is $clog2(PRESCALE) bits, minimum 1 bit.
  - Counts 0..PRESCALE-1 on enabled cycles and wraps to 0.
  - `tick` is 1 during the cycle where `pre_cnt`==PRESCALE-1.
  - With PRESCALE=1, `tick` is 1 on every enabled cycle.
- Stability counter `stab_cnt` is $clog2(STABLE_N+1) bits. It never exceeds STABLE_N-1 and cannot wrap.
- FSM state encoding: RELEASED=00, ARM_PRESS=01, PRESSED=10, ARM_RELEASE=11. `busy` = state[0].
- All transitions below happen only on cycles with `enable`=1 and `tick`=1. Otherwise state and `stab_cnt` hold.
  - RELEASED, `sync2`=1: go to ARM_PRESS, `stab_cnt`<=1.
  - RELEASED, `sync2`=0: stay.
  - ARM_PRESS, `sync2`=0: go to RELEASED, `stab_cnt`<=0. This rejects a bounce; no strobe.
  - ARM_PRESS, `sync2`=1 and `stab_cnt`==STABLE_N-1: go to PRESSED, `stab_cnt`<=0, `pb_clean`<=1, `press`<=1.
  - ARM_PRESS, `sync2`=1 otherwise: `stab_cnt`<=`stab_cnt`+1.
  - PRESSED and ARM_RELEASE mirror RELEASED and ARM_PRESS with `sync2` inverted. Acceptance sets `pb_clean`<=0 and `release`<=1.
- Strobes:
  - `press` and `release` are 0 on every cycle except the one immediately following acceptance.
  - They are forced to 0 on any cycle where `enable`=0 or `reset`=1.
  - They are never both 1.
- `enable`=0 freezes `sync1`, `sync2`, `pre_cnt`, state, `stab_cnt` and `pb_clean`.
- Reset:
  - All registers go to 0: state RELEASED, `pb_clean`=0, `press`=0, `release`=0, `busy`=0, `pre_cnt`=0, `stab_cnt`=0, `sync1`=`sync2`=0.
  - This holds regardless of `pb_in` or `enable`.
  - Reset in PRESSED does not generate a `release` strobe.

## Timing
- Synchronizer latency: 2 enabled cycles from `pb_in` to `sync2`.
- Acceptance latency: STABLE_N ticks after `sync2` changes, with a first-tick phase uncertainty of 0..PRESCALE-1 cycles.
- `pb_clean` edge and strobe appear together, 1 cycle after the accepting tick edge.
- With PRESCALE=4 and STABLE_N=4, and continuous `enable` (counting the first edge that samples the new `pb_in` as edge 1), `pb_clean` changes after edge 15..18.
- Minimum accepted pulse width is STABLE_N×PRESCALE enabled cycles. Any opposite sample within the window restarts from the base state.
- Reset takes effect at the first rising edge with `reset`=1. The first tick after reset release occurs on the PRESCALE-th enabled cycle.

## Test plan
All scenarios use PRESCALE=4, STABLE_N=4.
- Reset: `pb_in`=1, `reset`=1 for 2 cycles, `enable`=1 → `pb_clean`=`press`=`release`=`busy`=0. After release, `press` fires once, 15..18 edges later.
- Clean press/hold: `pb_in` 0→1, held 100 cycles → exactly one `press` pulse, 1 cycle wide; `pb_clean`=1 after edge 15..18; `busy`=1 only during the arm window; `release` stays 0.
- Bouncy press: `pb_in` toggles every 5 cycles ×6, then stays 0 → no `press`; `pb_clean` stays 0; `busy` pulses and ends 0 in RELEASED.
- Bouncy release: from PRESSED, toggle `pb_in` every 5 cycles ×4, then hold 0 → exactly one `release` 15..18 edges after the last edge; `pb_clean`→0 only then.
- Enable freeze: drop `enable` for 20 cycles after the 2nd stable tick of a press → `pre_cnt`, `stab_cnt` and state unchanged, no strobe. After re-enable, `press` fires 2 ticks (≤8 cycles) later.
- Reset mid-PRESSED: assert `reset` for 1 cycle with `pb_in`=1 → `pb_clean`=0 next edge, no `release`. `press` fires again 15..18 edges after reset deasserts.
